// File: rtl/alu_result_decoder_if.sv
// alu_result_decoder_if: ALU result handshake and display outputs between producer and decoder
interface alu_result_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] result;
  logic       overflow;
  logic       zero;
  logic       carry;
  logic [6:0] seg_sign;
  logic [6:0] seg_val;
  logic [2:0] led_flags;
  logic       busy;
  modport master (
    output in_valid, op, result, overflow, zero, carry,
    input  in_ready, seg_sign, seg_val, led_flags, busy
  );
  modport slave (
    input  in_valid, op, result, overflow, zero, carry,
    output in_ready, seg_sign, seg_val, led_flags, busy
  );
endinterface

// File: rtl/alu_result_decoder.sv
// alu_result_decoder: captures one ALU result per handshake and drives seven-segment/LED display with overflow blink
module alu_result_decoder #(
  parameter int BLINK_DIV = 25000000,
  parameter int ERR_HOLD  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_result_decoder_if.slave bus
);
  localparam int HW = $clog2(ERR_HOLD + 1);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic [1:0] {IDLE, SHOW, ERR} state_e;
  state_e        state_q;
  logic [HW-1:0] hold_q;
  logic [BW-1:0] blink_q;
  logic [6:0]    seg_sign_q, seg_val_q;
  logic [2:0]    led_q;
  logic          fire, arith, ovf_err;
  logic [3:0]    mag, digit;
  logic [6:0]    sign_d, val_d;
  logic [2:0]    led_d;
  always_comb begin
    fire    = bus.in_valid & bus.in_ready;
    arith   = bus.op[2:1] == 2'b00;
    ovf_err = arith & bus.overflow;
    mag     = bus.result[3] ? ~bus.result + 4'd1 : bus.result;
    digit   = arith ? mag : bus.op[2:1] == 2'b11 ? {3'b000, bus.result[0]} : bus.result;
    sign_d  = arith & ~bus.overflow & bus.result[3] ? SEG_MINUS : SEG_BLANK;
    val_d   = ovf_err ? SEG_E : SEG_LUT[digit];
    led_d   = arith ? {bus.overflow, bus.carry, bus.zero} : 3'b000;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      blink_q    <= '0;
      seg_sign_q <= SEG_BLANK;
      seg_val_q  <= SEG_BLANK;
      led_q      <= 3'b000;
    end else if (fire) begin
      state_q    <= ovf_err ? ERR : SHOW;
      hold_q     <= ovf_err ? HW'(ERR_HOLD) : '0;
      blink_q    <= '0;
      seg_sign_q <= sign_d;
      seg_val_q  <= val_d;
      led_q      <= led_d;
    end else if (state_q == ERR) begin
      hold_q    <= hold_q != '0 ? hold_q - 1'b1 : hold_q;
      blink_q   <= blink_q == BW'(BLINK_DIV - 1) ? '0 : blink_q + 1'b1;
      // flip the digit once per full half-period
      seg_val_q <= blink_q == BW'(BLINK_DIV - 1) ? (seg_val_q == SEG_E ? SEG_BLANK : SEG_E) : seg_val_q;
    end
  end
  assign bus.in_ready  = hold_q == '0;
  assign bus.busy      = hold_q != '0;
  assign bus.seg_sign  = seg_sign_q;
  assign bus.seg_val   = seg_val_q;
  assign bus.led_flags = led_q;
endmodule

// File: tb/tb_alu_result_decoder.sv
// tb_alu_result_decoder: random and directed stimulus checked against a cycle-count reference model
module tb_alu_result_decoder;
  localparam int BLINK_DIV = 3;
  localparam int ERR_HOLD  = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] E_SEG = 7'b0000110;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] seg_tbl [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  bit         m_err;
  int         m_k;
  logic [6:0] m_sign, m_val;
  logic [2:0] m_led;
  alu_result_decoder_if bus ();
  alu_result_decoder #(.BLINK_DIV(BLINK_DIV), .ERR_HOLD(ERR_HOLD)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit exp_ready();
    return !(m_err && m_k <= ERR_HOLD);
  endfunction
  task automatic cyc(input logic rn, input logic v, input logic [2:0] o, input logic [3:0] r,
                     input logic ov, input logic c, input logic z);
    bit fire;
    int s;
    rst_n        = rn;
    bus.in_valid = v;
    bus.op       = o;
    bus.result   = r;
    bus.overflow = ov;
    bus.carry    = c;
    bus.zero     = z;
    fire = rn && v && exp_ready();
    @(posedge clk);
    if (!rn) begin
      m_err = 0; m_k = 0; m_sign = BLANK; m_val = BLANK; m_led = 3'b000;
    end else if (fire) begin
      if (o <= 3'd1 && ov) begin
        m_err = 1; m_k = 1; m_sign = BLANK; m_led = {1'b1, c, z};
      end else begin
        m_err = 0;
        if (o <= 3'd1) begin
          s = r[3] ? int'(r) - 16 : int'(r);
          m_sign = s < 0 ? MINUS : BLANK;
          m_val  = seg_tbl[s < 0 ? -s : s];
          m_led  = {ov, c, z};
        end else begin
          m_sign = BLANK;
          m_val  = o >= 3'd6 ? seg_tbl[int'(r[0])] : seg_tbl[r];
          m_led  = 3'b000;
        end
      end
    end else if (m_err) begin
      m_k++;
    end
    #1;
    check("seg_sign", 32'(bus.seg_sign), 32'(m_sign));
    check("seg_val", 32'(bus.seg_val),
          32'(m_err ? (((m_k - 1) / BLINK_DIV) % 2 == 0 ? E_SEG : BLANK) : m_val));
    check("led_flags", 32'(bus.led_flags), 32'(m_led));
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready()));
    check("busy", 32'(bus.busy), 32'(!exp_ready()));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 3'd0, 4'd0, 0, 0, 0);
  endtask
  initial begin
    m_err = 0; m_k = 0; m_sign = BLANK; m_val = BLANK; m_led = 3'b000;
    cyc(0, 1, 3'd0, 4'd5, 0, 0, 0);
    cyc(0, 1, 3'd0, 4'd5, 0, 0, 0);
    cyc(1, 1, 3'd1, 4'b1101, 0, 1, 0);
    idle(2);
    cyc(1, 1, 3'd0, 4'b1000, 0, 0, 0);
    cyc(1, 1, 3'd3, 4'b1011, 0, 0, 0);
    cyc(1, 1, 3'd0, 4'b0111, 1, 0, 0);
    for (int i = 0; i < ERR_HOLD; i++) cyc(1, i[0], 3'd4, 4'd9, 0, 1, 1);
    idle(8);
    cyc(1, 1, 3'd7, 4'b0001, 0, 0, 0);
    idle(1);
    cyc(1, 1, 3'd1, 4'b1000, 1, 1, 1);
    idle(1);
    cyc(0, 1, 3'd4, 4'd2, 0, 0, 0);
    cyc(1, 1, 3'd4, 4'd5, 0, 0, 0);
    cyc(1, 1, 3'd4, 4'b0001, 0, 0, 0);
    cyc(1, 1, 3'd4, 4'b0010, 0, 0, 0);
    cyc(1, 1, 3'd4, 4'b0011, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 79) != 0, $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)),
          4'($urandom_range(0, 15)), $urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_result_decoder.md
Name: alu_result_decoder

Overview:
- Receives one ALU result per valid/ready transfer (op code, 4-bit result, overflow/zero/carry flags) and captures it in a display register.
- Converts it for the board display:
  - Arithmetic results are two's complement and are shown as a sign digit plus a decimal magnitude digit.
  - Logic results are shown as one hex digit.
  - Compare results are shown as 0/1.
- Overflow drives a timed error/blink state.
- Sits between the ALU output and the seven-segment/LED drivers.

Parameters:
BLINK_DIV, 25000000, clock cycles per blink half-period in ERR (minimum 2)
ERR_HOLD, 4, cycles in_ready stays low after an overflow capture (minimum 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  producer has a result this cycle
in_ready  output  1  block accepts a result this cycle
op  input  3  op code of result: 0 add, 1 sub, 2 not, 3 and, 4 or, 5 xor, 6 less, 7 equ
result  input  4  ALU result
overflow  input  1  ALU overflow flag
zero  input  1  ALU zero flag
carry  input  1  ALU carry flag
seg_sign  output  7  sign digit, {g,f,e,d,c,b,a}, active-low
seg_val  output  7  value digit, same encoding
led_flags  output  3  latched {overflow, carry, zero}, active-high
busy  output  1  high while in ERR hold window

Behaviour:
- Clock and reset: single clock domain clk; rst_n is synchronous and active-low. All state updates on the rising edge of clk.
- Segment codes, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - minus=0111111, blank=1111111.
- Transfer: occurs on a clock edge where in_valid and in_ready are both high. Inputs are sampled only at that edge. Outputs reflect the new value from the next cycle (1-cycle latency).
- FSM states: IDLE, SHOW, ERR.
- Reset (rst_n low at an edge), from any state including mid-blink or mid-hold:
  - state=IDLE; seg_sign=seg_val=blank; led_flags=000; busy=0; in_ready=1.
  - Hold and blink counters cleared.
- IDLE/SHOW:
  - in_ready=1.
  - A transfer with (op==0 or op==1) and overflow=1 goes to ERR.
  - Any other transfer goes to SHOW.
  - No transfer: the state and all outputs hold.
- Decode in SHOW:
  - op 0/1: sign = result[3].
    - magnitude = result when result[3]=0, else (~result+1) taken as a 4-bit unsigned value. 1000 therefore gives magnitude 8.
    - seg_sign = minus if sign, else blank. seg_val = decimal digit of magnitude (0..8).
  - op 2..5: seg_sign=blank; seg_val = hex digit of result.
  - op 6/7: seg_sign=blank; seg_val = digit of result[0].
  - led_flags = {overflow, carry, zero} for op 0/1; 000 for other ops.
- ERR:
  - On entry: seg_sign=blank; seg_val=E; led_flags={1,carry,zero}; busy=1; in_ready=0. Hold counter loaded with ERR_HOLD; blink counter cleared with the digit visible.
  - in_ready=0 and busy=1 for exactly ERR_HOLD cycles after the capture edge. After that, in_ready=1 and busy=0 while remaining in ERR.
  - Blinking: seg_val alternates E / blank every BLINK_DIV cycles for as long as ERR is held.
  - Exit: a transfer in ERR after the hold window applies the same next-state rule as IDLE/SHOW, so an overflowing result re-enters ERR with the hold restarted.
- in_valid while in_ready=0: ignored, nothing captured. The producer is required to hold its data stable.
- No internal queueing: depth is one displayed entry.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 -> blank/blank, led_flags=000, in_ready=1, busy=0.
- Negative sub result: op=1, result=1101, overflow=0, carry=1, zero=0 -> next cycle seg_sign=0111111, seg_val=0110000 ('3'), led_flags=010.
- Corner value: op=0, result=1000, overflow=0 -> seg_sign=minus, seg_val=0000000 ('8'). Then op=3, result=1011 -> seg_sign=blank, seg_val=0000011 ('b'), led_flags=000.
- Overflow, with ERR_HOLD=4 and BLINK_DIV=3: op=0, overflow=1, carry=0, zero=0 ->
  - seg_val=E, led_flags=100.
  - busy=1 and in_ready=0 for 4 cycles; in_valid pulses during that window are not captured.
  - seg_val toggles E/blank every 3 cycles.
  - A subsequent op=7, result=0001 -> SHOW with '1', busy=0.
- Reset mid-ERR: assert rst_n=0 during the hold window -> IDLE, blank, in_ready=1 next cycle. A transfer after release displays normally.
- Back-to-back: in_valid held high for 3 cycles with results 0001, 0010, 0011 (op=4) -> seg_val shows '1', '2', '3' on consecutive cycles; in_ready stays 1.
